// File: rtl/flash_read_arbiter.sv
// Two-port arbiter that serialises 32-bit reads (command 03h) onto an SPI mode-0 flash.
// Defining FLASH_WAKE_EN adds a release-power-down (ABh) and a WAKE_CYCLES wait after reset.
module flash_read_arbiter #(
`ifdef FLASH_WAKE_EN
  parameter int WAKE_CYCLES    = 36,
`endif
  parameter int CS_IDLE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        busy,
  output logic        flashClk,
  output logic        flashMosi,
  output logic        flashCs,
  input  logic        flashMiso
);

  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [15:0] GAP_LAST   = (CS_IDLE_CYCLES > 1) ? 16'(CS_IDLE_CYCLES - 1) : 16'd0;
  localparam logic [15:0] SHIFT_LAST = 16'd128;
`ifdef FLASH_WAKE_EN
  localparam logic [2:0]  S_WAKE      = 3'd0;
  localparam logic [2:0]  S_WAKE_WAIT = 3'd1;
  localparam logic [15:0] WAKE_SHIFT_LAST = 16'd16;
  localparam logic [15:0] WAKE_LAST  = (WAKE_CYCLES > 1) ? 16'(WAKE_CYCLES - 1) : 16'd0;
  localparam logic [2:0]  RESET_STATE = S_WAKE;
  localparam logic [31:0] RESET_TX    = 32'hAB00_0000;
`else
  localparam logic [2:0]  RESET_STATE = S_IDLE;
  localparam logic [31:0] RESET_TX    = 32'h0000_0000;
`endif

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] txSr_q, txSr_d;
  logic [31:0] rxSr_q, rxSr_d;
  logic        port_q, port_d;
  logic        lastGrant_q, lastGrant_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        ack0_q, ack1_q;
  logic        flashCs_q, flashClk_q, flashMosi_q;
  logic        sclkHigh;
  logic        grant;
  logic        active_d;

  function automatic logic [31:0] byteSwap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Shift counter 0 is a CS-setup cycle; flashClk is high on every even nonzero count.
  assign sclkHigh = (cnt_q != 16'd0) && !cnt_q[0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    txSr_d      = txSr_q;
    rxSr_d      = rxSr_q;
    port_d      = port_q;
    lastGrant_d = lastGrant_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    grant       = 1'b0;
    case (state_q)
`ifdef FLASH_WAKE_EN
      S_WAKE: begin
        cnt_d = cnt_q + 16'd1;
        if (sclkHigh) txSr_d = {txSr_q[30:0], 1'b0};
        if (cnt_q == WAKE_SHIFT_LAST) begin
          state_d = S_WAKE_WAIT;
          cnt_d   = 16'd0;
        end
      end
      S_WAKE_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == WAKE_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end
      end
`endif
      S_IDLE: begin
        if (req0 || req1) begin
          grant       = (req0 && req1) ? ~lastGrant_q : req1;
          port_d      = grant;
          lastGrant_d = grant;
          txSr_d      = {8'h03, grant ? addr1 : addr0};
          cnt_d       = 16'd0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 16'd1;
        if (sclkHigh) begin
          txSr_d = {txSr_q[30:0], 1'b0};
          rxSr_d = {rxSr_q[30:0], flashMiso};
        end
        if (cnt_q == SHIFT_LAST) begin
          state_d = S_DONE;
          cnt_d   = 16'd0;
          if (port_q) rdata1_d = byteSwap(rxSr_d);
          else        rdata0_d = byteSwap(rxSr_d);
        end
      end
      S_DONE: begin
        state_d = S_GAP;
        cnt_d   = 16'd0;
      end
      S_GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

`ifdef FLASH_WAKE_EN
  assign active_d = (state_d == S_SHIFT) || (state_d == S_WAKE);
`else
  assign active_d = (state_d == S_SHIFT);
`endif

  // Pins are registered from next-state values so they change glitch-free with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      cnt_q       <= 16'd0;
      txSr_q      <= RESET_TX;
      rxSr_q      <= 32'd0;
      port_q      <= 1'b1;
      lastGrant_q <= 1'b1;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      flashCs_q   <= 1'b1;
      flashClk_q  <= 1'b0;
      flashMosi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      txSr_q      <= txSr_d;
      rxSr_q      <= rxSr_d;
      port_q      <= port_d;
      lastGrant_q <= lastGrant_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      ack0_q      <= (state_d == S_DONE) && !port_d;
      ack1_q      <= (state_d == S_DONE) && port_d;
      flashCs_q   <= !active_d;
      flashClk_q  <= active_d && (cnt_d != 16'd0) && !cnt_d[0];
      flashMosi_q <= active_d && txSr_d[31];
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign flashCs   = flashCs_q;
  assign flashClk  = flashClk_q;
  assign flashMosi = flashMosi_q;
  assign busy      = !reset_n || (state_q != S_IDLE);

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with a behavioural SPI flash answering 03h reads.
// Build with FLASH_WAKE_EN to exercise the wake-up sequence as well.
module tb_flash_read_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [23:0] addr0 = 24'h0, addr1 = 24'h0;
  logic        ack0, ack1, busy;
  logic [31:0] rdata0, rdata1;
  logic        flashClk, flashMosi, flashCs;
  logic        flashMiso = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  flash_read_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .flashClk(flashClk), .flashMosi(flashMosi),
    .flashCs(flashCs), .flashMiso(flashMiso)
  );

  // Flash model: bytes of flashWord are returned MSB-first, flashWord[31:24] first.
  logic [31:0] flashWord = 32'h0;
  logic [31:0] mosiCap = 32'h0;
  logic [31:0] wakeCap = 32'h0;
  int          riseCnt = 0;
  int          wakeRise = 0;
  bit          wakeSeen = 1'b0;

  always @(posedge flashClk or flashCs) begin
    if (flashCs) begin
      if (!wakeSeen && riseCnt > 0) begin
        wakeCap  = mosiCap;
        wakeRise = riseCnt;
        wakeSeen = 1'b1;
      end
    end else if (flashClk) begin
      if (riseCnt < 32) mosiCap = {mosiCap[30:0], flashMosi};
      riseCnt = riseCnt + 1;
    end else begin
      riseCnt = 0;
      mosiCap = 32'h0;
    end
  end

  always @(negedge flashClk) begin
    if (!flashCs && riseCnt >= 32 && riseCnt < 64) flashMiso = flashWord[63 - riseCnt];
  end

  // Pin-level monitor: ack counts, protocol violations and length of each flashCs-high gap.
  int ack0Cnt = 0, ack1Cnt = 0, protoViol = 0, csRun = 0, lastGap = 0;
  always @(negedge clock) begin
    if (ack0) ack0Cnt++;
    if (ack1) ack1Cnt++;
    if (ack0 && ack1) protoViol++;
    if (flashCs && flashClk) protoViol++;
    if (flashCs) csRun++;
    else begin
      if (csRun > 0) lastGap = csRun;
      csRun = 0;
    end
  end

  typedef struct {
    logic        req0;
    logic        req1;
    logic [23:0] addr0;
    logic [23:0] addr1;
    logic [31:0] stream;
    logic        expPort;
    logic [31:0] expMosi;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic noteTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual timeout required event", name);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (!busy) return;
    end
    noteTimeout("waitIdle");
  endtask

  // Counts cycles until an ack is seen; returns at the negedge of the ack cycle.
  task automatic waitAck(input string name, output int cycles, output logic port, output bit ok);
    cycles = 0;
    port   = 1'b0;
    ok     = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(posedge clock);
      @(negedge clock);
      cycles++;
      if (ack0 || ack1) begin
        port = ack1;
        ok   = 1'b1;
        return;
      end
    end
    noteTimeout(name);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int   cyc;
    logic port;
    bit   ok;
    waitIdle();
    flashWord = v.stream;
    addr0 = v.addr0;
    addr1 = v.addr1;
    req0  = v.req0;
    req1  = v.req1;
    waitAck({tag, " ack"}, cyc, port, ok);
    if (ok) begin
      checkOutput({tag, " latency"}, 32'(cyc), 32'd130);
      checkOutput({tag, " port"}, 32'(port), 32'(v.expPort));
      checkOutput({tag, " rdata"}, port ? rdata1 : rdata0, v.expRdata);
      checkOutput({tag, " mosi"}, mosiCap, v.expMosi);
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: actual still running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cyc;
    int   a0, a1;
    logic port;
    bit   ok;

    vecs[0] = '{1'b1, 1'b0, 24'h000100, 24'h000000, 32'h11223344, 1'b0, 32'h03000100, 32'h44332211};
    vecs[1] = '{1'b0, 1'b1, 24'h000000, 24'hABCDEF, 32'hDEADBEEF, 1'b1, 32'h03ABCDEF, 32'hEFBEADDE};
    vecs[2] = '{1'b1, 1'b0, 24'hFFFFFF, 24'h000000, 32'h00000000, 1'b0, 32'h03FFFFFF, 32'h00000000};
    vecs[3] = '{1'b0, 1'b1, 24'h000000, 24'h000000, 32'hFFFFFFFF, 1'b1, 32'h03000000, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 1'b0, 24'h800001, 24'h000000, 32'h80010203, 1'b0, 32'h03800001, 32'h03020180};
    vecs[5] = '{1'b1, 1'b0, 24'h0A0B0C, 24'h000000, 32'hCAFEF00D, 1'b0, 32'h030A0B0C, 32'h0DF0FECA};

    // Reset values are forced while reset_n is low.
    repeat (3) @(negedge clock);
    checkOutput("reset pins {cs,clk,mosi,ack0,ack1,busy}",
                32'({flashCs, flashClk, flashMosi, ack0, ack1, busy}), 32'b100001);
    checkOutput("reset rdata0", rdata0, 32'h0);
    checkOutput("reset rdata1", rdata1, 32'h0);

`ifdef FLASH_WAKE_EN
    req1      = 1'b1;
    addr1     = 24'h123456;
    flashWord = 32'hA1B2C3D4;
    reset_n   = 1'b1;
    waitAck("wake ack", cyc, port, ok);
    if (ok) begin
      checkOutput("wake cmd bits", wakeCap, 32'h000000AB);
      checkOutput("wake cmd pulses", 32'(wakeRise), 32'd8);
      checkOutput("wake gap", 32'(lastGap), 32'd37);
      checkOutput("wake port", 32'(port), 32'd1);
      checkOutput("wake rdata1", rdata1, 32'hD4C3B2A1);
      checkOutput("wake mosi", mosiCap, 32'h03123456);
    end
    req1 = 1'b0;
`else
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("idle after reset busy", 32'(busy), 32'd0);
`endif

    // Simultaneous requests: port 0 first, port 1 after the gap, then port 0 again.
    for (int round = 0; round < 2; round++) begin
      waitIdle();
      flashWord = 32'h55AA0FF0;
      addr0 = 24'h010203 + 24'(round);
      addr1 = 24'h0C0D0E + 24'(round);
      req0  = 1'b1;
      req1  = 1'b1;
      waitAck("tie first ack", cyc, port, ok);
      if (ok) begin
        checkOutput("tie first latency", 32'(cyc), 32'd130);
        checkOutput("tie first port", 32'(port), 32'd0);
        checkOutput("tie rdata0", rdata0, 32'hF00FAA55);
      end
      req0 = 1'b0;
      waitAck("tie second ack", cyc, port, ok);
      if (ok) begin
        checkOutput("tie ack-to-ack cycles", 32'(cyc), 32'd133);
        checkOutput("tie second port", 32'(port), 32'd1);
        checkOutput("tie rdata1", rdata1, 32'hF00FAA55);
        checkOutput("tie second mosi", mosiCap, {8'h03, 24'h0C0D0E + 24'(round)});
        checkOutput("tie cs gap", 32'(lastGap), 32'd4);
      end
      req1 = 1'b0;
    end

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));
    checkOutput("rdata0 held", rdata0, 32'h03020180);

    // Reset pulsed during the 40th SHIFT cycle aborts the read with no ack.
    waitIdle();
    a0 = ack0Cnt;
    flashWord = 32'h12345678;
    addr0 = 24'h0A0B0C;
    req0  = 1'b1;
    repeat (40) @(posedge clock);
    #2;
    checkOutput("pre-reset cs", 32'(flashCs), 32'd0);
    reset_n = 1'b0;
    req0 = 1'b0;
    #1;
    checkOutput("mid reset {cs,clk,ack0}", 32'({flashCs, flashClk, ack0}), 32'b100);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    waitIdle();
    @(posedge clock);
    checkOutput("no ack after abort", 32'(ack0Cnt - a0), 32'd0);
    applyStimulus(vecs[5], "reissue");

    // Port 1 drops its request 10 cycles after the grant; the read still completes once.
    waitIdle();
    a0 = ack0Cnt;
    a1 = ack1Cnt;
    flashWord = 32'h5A6B7C8D;
    addr1 = 24'h00FF00;
    req1  = 1'b1;
    repeat (11) @(posedge clock);
    #1 req1 = 1'b0;
    waitAck("drop ack", cyc, port, ok);
    if (ok) begin
      checkOutput("drop latency", 32'(cyc + 11), 32'd130);
      checkOutput("drop port", 32'(port), 32'd1);
      checkOutput("drop rdata1", rdata1, 32'h8D7C6B5A);
      checkOutput("drop mosi", mosiCap, 32'h0300FF00);
    end
    flashWord = 32'h01020304;
    addr0 = 24'h000004;
    req0  = 1'b1;
    waitAck("follow ack", cyc, port, ok);
    if (ok) begin
      checkOutput("follow port", 32'(port), 32'd0);
      checkOutput("follow rdata0", rdata0, 32'h04030201);
      checkOutput("follow cs gap", 32'(lastGap), 32'd4);
    end
    req0 = 1'b0;
    @(posedge clock);
    checkOutput("drop ack1 pulses", 32'(ack1Cnt - a1), 32'd1);
    checkOutput("drop ack0 pulses", 32'(ack0Cnt - a0), 32'd1);

    checkOutput("protocol violations", 32'(protoViol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
